// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit geometry and counter width for the NoC ejection path
package noc_pkg;

    localparam int unsigned FLIT_W      = 20;
    localparam int unsigned PAYLOAD_W   = 16;
    localparam int unsigned DEST_W      = 4;
    localparam int unsigned PAYLOAD_LSB = 4;
    localparam int unsigned DEST_LSB    = 0;
    localparam int unsigned CNT_W       = 16;

    function automatic logic [DEST_W-1:0] flit_dest(input logic [FLIT_W-1:0] flit);
        return flit[DEST_LSB +: DEST_W];
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// rtl/noc_flit_fifo.sv - show-ahead circular flit FIFO with push/pop/full/empty/count
module noc_flit_fifo
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [FLIT_W-1:0]        din,
    output logic [FLIT_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_eject_if.sv
// rtl/noc_eject_if.sv - NoC ejection stage: dest check, FIFO, credits, stats (NOC_EJECT_STATS_EN)
module noc_eject_if
    import noc_pkg::*;
#(
    parameter int unsigned NODE_ID    = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flit_valid,
    input  logic [FLIT_W-1:0]    flit_in,
    output logic [1:0]           credit_ret,
    output logic                 out_valid,
    output logic [FLIT_W-1:0]    out_data,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     rx_cnt,
    output logic [CNT_W-1:0]     misroute_cnt,
    output logic                 overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          match;
    logic          mis;
    logic          pop;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          ovf_event;

    assign match = flit_valid && (flit_dest(flit_in) == DEST_W'(NODE_ID));
    assign mis   = flit_valid && (flit_dest(flit_in) != DEST_W'(NODE_ID));

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts when its head leaves on the same edge.
    assign push      = match && (!fifo_full || pop);
    assign ovf_event = match && (fifo_count == CW'(FIFO_DEPTH)) && !pop;

    noc_flit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (flit_in),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Misrouted flits still consumed a router credit, so they return one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_ret <= 2'd0;
        end else begin
            credit_ret <= {1'b0, pop} + {1'b0, mis};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (ovf_event) begin
            overflow <= 1'b1;
        end
    end

`ifdef NOC_EJECT_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt       <= '0;
            misroute_cnt <= '0;
        end else begin
            if (push && (rx_cnt != '1))
                rx_cnt <= rx_cnt + CNT_W'(1);
            if (mis && (misroute_cnt != '1))
                misroute_cnt <= misroute_cnt + CNT_W'(1);
        end
    end
`else
    assign rx_cnt       = '0;
    assign misroute_cnt = '0;
`endif

endmodule
